bram_access_arbiter: RTL and testbench
======================================

Name: bram_access_arbiter

Overview:
- Shares the single-port RGB frame BRAM between two requesters: the SPI data-transfer controller (com, one 8-bit colour lane per access) and the image-processing engine (pdi, full 24-bit RGB per access).
- Sits between both requesters and the three channel memories, in place of the static pdi_active mux.
- Provides a req/gnt handshake, bounded-burst fair arbitration, a pdi lock mode, and read-data return routed to the requester that issued the read.

Parameters:
- ADDR_W, 17, BRAM address width (320x240 pixels fits in 17 bits).
- RD_LAT, 1, BRAM read latency in cycles, measured from the registered mem_addr to valid mem_rdata.
- MAX_BURST, 16, maximum consecutive grants to one owner while the other requester is waiting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- com_req  in  1  com access request, held until granted
- com_we  in  1  1 = write, 0 = read
- com_addr  in  ADDR_W  com address
- com_channel  in  2  lane select: 0 = R, 1 = G, 2 = B, 3 = all lanes
- com_wdata  in  8  com write byte
- com_gnt  out  1  access accepted this cycle
- com_rvalid  out  1  com_rdata valid
- com_rdata  out  8  read byte for the lane captured at grant
- pdi_req  in  1  pdi access request
- pdi_we  in  1  1 = write
- pdi_addr  in  ADDR_W  pdi address
- pdi_wdata  in  24  {R,G,B} write data
- pdi_gnt  out  1  access accepted
- pdi_rvalid  out  1  pdi_rdata valid
- pdi_rdata  out  24  {R,G,B} read data
- pdi_lock  in  1  pdi has absolute priority while high (processing active)
- mem_addr  out  ADDR_W  registered BRAM address
- mem_we  out  3  registered per-lane write enables, bit2 = R, bit1 = G, bit0 = B
- mem_wdata  out  24  registered {R,G,B} write data
- mem_rdata  in  24  BRAM read data
- owner  out  2  0 = idle, 1 = com, 2 = pdi

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state IDLE; all outputs 0.
  - Read-return pipeline flushed; in-flight reads never produce rvalid.
  - last_owner = pdi, so com wins the first tie.
  - Burst counter = 0.
- FSM states:
  - IDLE: no grants. Next state:
    - PDI if pdi_req and (pdi_lock or !com_req or last_owner == com);
    - else COM if com_req;
    - else IDLE.
    - The first grant therefore comes one cycle after req rises from IDLE.
  - COM: com_gnt = com_req (combinational from the registered state). Go to IDLE when:
    - com_req = 0; or
    - pdi_req = 1 and (pdi_lock = 1 or burst == MAX_BURST-1 on a granted cycle).
  - PDI: pdi_gnt = pdi_req. Go to IDLE when:
    - pdi_req = 0; or
    - com_req = 1 and pdi_lock = 0 and burst == MAX_BURST-1 on a granted cycle.
- Handover: every owner change passes through IDLE, giving one dead cycle. last_owner updates on leaving COM or PDI.
- Burst counter:
  - Increments on each grant and clears on entering IDLE.
  - Saturates, does not wrap, while the other requester is idle.
- com_gnt and pdi_gnt are never high in the same cycle.
- Issue: on a gnt cycle, mem_addr, mem_we and mem_wdata are registered at the next edge. They are held one cycle; mem_we returns to 0 afterwards unless another write is granted.
- com write lane mapping:
  - channel 0: mem_we = 100, wdata = {b,0,0}.
  - channel 1: mem_we = 010, wdata = {0,b,0}.
  - channel 2: mem_we = 001, wdata = {0,0,b}.
  - channel 3: mem_we = 111, wdata = {b,b,b}.
- pdi write: mem_we = 111, mem_wdata = pdi_wdata.
- Read: mem_we = 000.
  - A tag {valid, owner, channel} enters a shift register of depth RD_LAT+1.
  - rvalid is asserted exactly RD_LAT+1 cycles after the gnt cycle, for one cycle, to the tagged owner only.
  - com_rdata is the lane of mem_rdata selected by the captured channel; channel 3 returns R.
  - pdi_rdata = mem_rdata.
  - Reads in flight complete even if ownership changes.
- Back-to-back: one access per cycle while the owner holds req; reads and writes interleave freely.
- Request inputs: address and data are sampled only on gnt cycles. A requester dropping req with no gnt is legal and causes no access.
- pdi_lock rising while COM owns: com gets at most one more grant (the current cycle), then IDLE, then PDI.
- Both req deasserted in COM or PDI: return to IDLE; mem_we = 0.

Test Plan:
- Reset, then com_req alone: write addr 5, channel 1, data 0xA5.
  - com_gnt in cycle 2; next cycle mem_addr = 5, mem_we = 010, mem_wdata = 0x00A500.
- pdi read addr 0x1FFFF with RD_LAT = 1 and mem_rdata = 0x123456 returned.
  - pdi_rvalid exactly 2 cycles after pdi_gnt, pdi_rdata = 0x123456, com_rvalid stays 0.
- Both requesters held continuously, pdi_lock = 0, MAX_BURST = 16.
  - Grants alternate 16 com, 1 idle, 16 pdi, 1 idle; com is served first after reset; gnts are never simultaneous.
- COM owning mid-burst, pdi_lock rises with pdi_req.
  - At most 1 further com_gnt, one idle cycle, then continuous pdi_gnt; com is starved while the lock holds.
- com read channel 2 at addr 7, then immediate handover to a pdi write.
  - com_rvalid fires with the B byte despite the owner change; the pdi write shows mem_we = 111.
- rst driven low while a read is in flight.
  - No rvalid on either port; all outputs 0 on the next cycle; state IDLE.

Source files
------------

// File: rtl/bram_access_arbiter.sv
// Arbitrates the single-port RGB frame BRAM between the SPI byte-lane requester (com)
// and the 24-bit image-processing requester (pdi), returning read data to its issuer.
module bram_access_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              com_req,
  input  logic              com_we,
  input  logic [ADDR_W-1:0] com_addr,
  input  logic [1:0]        com_channel,
  input  logic [7:0]        com_wdata,
  output logic              com_gnt,
  output logic              com_rvalid,
  output logic [7:0]        com_rdata,
  input  logic              pdi_req,
  input  logic              pdi_we,
  input  logic [ADDR_W-1:0] pdi_addr,
  input  logic [23:0]       pdi_wdata,
  output logic              pdi_gnt,
  output logic              pdi_rvalid,
  output logic [23:0]       pdi_rdata,
  input  logic              pdi_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_we,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic [1:0]        owner
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COM  = 2'd1,
    ST_PDI  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       is_com;
    logic [1:0] ch;
  } tag_t;

  state_t          state_r, state_s;
  logic            last_com_r;
  logic [BW-1:0]   burst_r;
  logic            burst_top_s;
  logic            com_gnt_s, pdi_gnt_s;
  tag_t            tag_s;
  tag_t            tag_r [0:RD_LAT];

  function automatic logic [2:0] lane_we(input logic [1:0] ch);
    case (ch)
      2'd0:    lane_we = 3'b100;
      2'd1:    lane_we = 3'b010;
      2'd2:    lane_we = 3'b001;
      default: lane_we = 3'b111;
    endcase
  endfunction

  function automatic logic [23:0] lane_data(input logic [1:0] ch, input logic [7:0] b);
    case (ch)
      2'd0:    lane_data = {b, 8'h00, 8'h00};
      2'd1:    lane_data = {8'h00, b, 8'h00};
      2'd2:    lane_data = {8'h00, 8'h00, b};
      default: lane_data = {b, b, b};
    endcase
  endfunction

  // Channel 3 (all lanes) reads back the R byte.
  function automatic logic [7:0] lane_pick(input logic [1:0] ch, input logic [23:0] d);
    case (ch)
      2'd1:    lane_pick = d[15:8];
      2'd2:    lane_pick = d[7:0];
      default: lane_pick = d[23:16];
    endcase
  endfunction

  assign burst_top_s = (burst_r == BW'(MAX_BURST - 1));

  // Next-state and grant decode; every handover passes through IDLE.
  always_comb begin
    state_s   = state_r;
    com_gnt_s = 1'b0;
    pdi_gnt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pdi_req && (pdi_lock || !com_req || last_com_r)) begin
          state_s = ST_PDI;
        end else if (com_req) begin
          state_s = ST_COM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COM: begin
        com_gnt_s = com_req;
        if (!com_req || (pdi_req && (pdi_lock || burst_top_s))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_COM;
        end
      end
      ST_PDI: begin
        pdi_gnt_s = pdi_req;
        if (!pdi_req || (com_req && !pdi_lock && burst_top_s)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PDI;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, last owner and burst counter (saturating, cleared on entering IDLE).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      last_com_r <= 1'b0;
      burst_r    <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_COM && state_s == ST_IDLE) begin
        last_com_r <= 1'b1;
      end else if (state_r == ST_PDI && state_s == ST_IDLE) begin
        last_com_r <= 1'b0;
      end
      if (state_s == ST_IDLE) begin
        burst_r <= '0;
      end else if ((com_gnt_s || pdi_gnt_s) && !burst_top_s) begin
        burst_r <= burst_r + BW'(1);
      end
    end
  end

  // Issue register toward the BRAM; write enables last exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_we    <= 3'b000;
      mem_wdata <= 24'h000000;
    end else if (com_gnt_s) begin
      mem_addr  <= com_addr;
      mem_we    <= com_we ? lane_we(com_channel) : 3'b000;
      mem_wdata <= lane_data(com_channel, com_wdata);
    end else if (pdi_gnt_s) begin
      mem_addr  <= pdi_addr;
      mem_we    <= pdi_we ? 3'b111 : 3'b000;
      mem_wdata <= pdi_wdata;
    end else begin
      mem_we    <= 3'b000;
    end
  end

  always_comb begin
    tag_s.valid  = (com_gnt_s && !com_we) || (pdi_gnt_s && !pdi_we);
    tag_s.is_com = com_gnt_s;
    tag_s.ch     = com_channel;
  end

  // Read-return tag pipeline; the tail lines up with mem_rdata of the tagged read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      tag_r[0] <= tag_s;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  assign com_gnt    = com_gnt_s;
  assign pdi_gnt    = pdi_gnt_s;
  assign owner      = state_r;
  assign com_rvalid = tag_r[RD_LAT].valid && tag_r[RD_LAT].is_com;
  assign pdi_rvalid = tag_r[RD_LAT].valid && !tag_r[RD_LAT].is_com;
  assign com_rdata  = com_rvalid ? lane_pick(tag_r[RD_LAT].ch, mem_rdata) : 8'h00;
  assign pdi_rdata  = pdi_rvalid ? mem_rdata : 24'h000000;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Self-checking bench for bram_access_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model with its own shadow frame memory.
module tb_bram_access_arbiter;
  localparam int ADDR_W = 17, RD_LAT = 1, MAX_BURST = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic com_req = 1'b0, com_we = 1'b0, pdi_req = 1'b0, pdi_we = 1'b0, pdi_lock = 1'b0;
  logic [ADDR_W-1:0] com_addr = '0, pdi_addr = '0;
  logic [1:0] com_channel = 2'd0;
  logic [7:0] com_wdata = 8'h00;
  logic [23:0] pdi_wdata = 24'h0;
  logic com_gnt, com_rvalid, pdi_gnt, pdi_rvalid;
  logic [7:0] com_rdata;
  logic [23:0] pdi_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0] mem_we;
  logic [1:0] owner;

  bram_access_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .com_req(com_req), .com_we(com_we), .com_addr(com_addr), .com_channel(com_channel),
    .com_wdata(com_wdata), .com_gnt(com_gnt), .com_rvalid(com_rvalid), .com_rdata(com_rdata),
    .pdi_req(pdi_req), .pdi_we(pdi_we), .pdi_addr(pdi_addr), .pdi_wdata(pdi_wdata),
    .pdi_gnt(pdi_gnt), .pdi_rvalid(pdi_rvalid), .pdi_rdata(pdi_rdata), .pdi_lock(pdi_lock),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Environment BRAM: read-first, RD_LAT cycles from the registered address.
  bit [23:0] bram [0:(1<<ADDR_W)-1];
  logic [23:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= bram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_we != 3'b000)
      bram[mem_addr] <= (bram[mem_addr] & ~{{8{mem_we[2]}}, {8{mem_we[1]}}, {8{mem_we[0]}}})
                      | (mem_wdata & {{8{mem_we[2]}}, {8{mem_we[1]}}, {8{mem_we[0]}}});
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  int n_checks = 0, n_errors = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; bit is_com; logic [1:0] ch; logic [23:0] data; } rd_t;
  rd_t pend [$];
  bit [23:0] ref_mem [0:(1<<ADDR_W)-1];
  int m_cur = 0, m_run = 0, m_last = 2;   // owner: 0 none, 1 com, 2 pdi
  logic [ADDR_W-1:0] e_addr = '0;
  logic [2:0] e_we = 3'b000;
  logic [23:0] e_wdata = 24'h0;

  function automatic logic [7:0] pick(input logic [1:0] ch, input logic [23:0] d);
    int sh;
    sh = (ch == 2'd3) ? 16 : 16 - 8 * int'(ch);
    return d[sh +: 8];
  endfunction

  // One clock cycle: check this cycle's outputs, then advance the model across the edge.
  task automatic tick();
    rd_t r;
    bit eg_c, eg_p, ev_c, ev_p, leave;
    logic [2:0] msk;
    logic [23:0] m24;
    #1;
    eg_c = (m_cur == 1) && com_req;
    eg_p = (m_cur == 2) && pdi_req;
    check_eq("com_gnt", 32'(com_gnt), 32'(eg_c));
    check_eq("pdi_gnt", 32'(pdi_gnt), 32'(eg_p));
    check_eq("gnt_excl", 32'(com_gnt & pdi_gnt), 32'd0);
    check_eq("owner", 32'(owner), 32'(m_cur));
    check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
    check_eq("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we != 3'b000) check_eq("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    ev_c = 1'b0; ev_p = 1'b0;
    r.due = 0; r.is_com = 1'b0; r.ch = 2'd0; r.data = 24'h0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      ev_c = r.is_com;
      ev_p = !r.is_com;
    end
    check_eq("com_rvalid", 32'(com_rvalid), 32'(ev_c));
    check_eq("pdi_rvalid", 32'(pdi_rvalid), 32'(ev_p));
    if (ev_c) check_eq("com_rdata", 32'(com_rdata), 32'(pick(r.ch, r.data)));
    if (ev_p) check_eq("pdi_rdata", 32'(pdi_rdata), 32'(r.data));
    if (!rst) begin
      m_cur = 0; m_run = 0; m_last = 2; pend.delete();
      e_addr = '0; e_we = 3'b000; e_wdata = 24'h0;
    end else begin
      if (eg_c) begin
        msk = (com_channel == 2'd3) ? 3'b111 : (3'b100 >> com_channel);
        m24 = {{8{msk[2]}}, {8{msk[1]}}, {8{msk[0]}}};
        e_addr = com_addr;
        if (com_we) begin
          e_we = msk;
          e_wdata = {3{com_wdata}} & m24;
          ref_mem[com_addr] = (ref_mem[com_addr] & ~m24) | e_wdata;
        end else begin
          e_we = 3'b000;
          pend.push_back('{cyc + RD_LAT + 1, 1'b1, com_channel, ref_mem[com_addr]});
        end
      end else if (eg_p) begin
        e_addr = pdi_addr;
        if (pdi_we) begin
          e_we = 3'b111; e_wdata = pdi_wdata; ref_mem[pdi_addr] = pdi_wdata;
        end else begin
          e_we = 3'b000;
          pend.push_back('{cyc + RD_LAT + 1, 1'b0, 2'd0, ref_mem[pdi_addr]});
        end
      end else begin
        e_we = 3'b000;
      end
      // m_run counts grants already given in the current ownership run
      case (m_cur)
        0: if (pdi_req && (pdi_lock || !com_req || m_last == 1)) m_cur = 2;
           else if (com_req) m_cur = 1;
        1: begin
          leave = !com_req || (pdi_req && (pdi_lock || m_run >= MAX_BURST - 1));
          if (leave) begin m_cur = 0; m_last = 1; m_run = 0; end else m_run++;
        end
        default: begin
          leave = !pdi_req || (com_req && !pdi_lock && m_run >= MAX_BURST - 1);
          if (leave) begin m_cur = 0; m_last = 2; m_run = 0; end else m_run++;
        end
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [ADDR_W-1:0] ca,
                       input logic [1:0] cc, input logic [7:0] cd, input bit pr, input bit pw,
                       input logic [ADDR_W-1:0] pa, input logic [23:0] pd, input bit lk);
    com_req = cr; com_we = cw; com_addr = ca; com_channel = cc; com_wdata = cd;
    pdi_req = pr; pdi_we = pw; pdi_addr = pa; pdi_wdata = pd; pdi_lock = lk;
  endtask

  bit gc [1:62];
  bit gp [1:62];
  int s0, s1;
  bit lk;

  initial begin
    repeat (2) @(negedge clk);
    tick();                       // reset cycle: model expects every output at 0
    rst = 1'b1;

    // com write lane 1 from idle
    drive(1, 1, 17'd5, 2'd1, 8'hA5, 0, 0, '0, 24'h0, 0); tick();
    drive(1, 1, 17'd5, 2'd1, 8'hA5, 0, 0, '0, 24'h0, 0); #1;
    check_eq("t1_gnt_cycle2", 32'(com_gnt), 32'd1); tick();
    drive(0, 0, '0, 2'd0, 8'h00, 0, 0, '0, 24'h0, 0); #1;
    check_eq("t1_addr", 32'(mem_addr), 32'd5);
    check_eq("t1_we", 32'(mem_we), 32'b010);
    check_eq("t1_wdata", 32'(mem_wdata), 32'h00A500);
    tick();

    // pdi write then read at the top address
    drive(0, 0, '0, 2'd0, 8'h00, 1, 1, 17'h1FFFF, 24'h123456, 0); tick();
    drive(0, 0, '0, 2'd0, 8'h00, 1, 1, 17'h1FFFF, 24'h123456, 0); #1;
    check_eq("t2_wr_gnt", 32'(pdi_gnt), 32'd1); tick();
    drive(0, 0, '0, 2'd0, 8'h00, 1, 0, 17'h1FFFF, 24'h0, 0); tick();
    drive(0, 0, '0, 2'd0, 8'h00, 0, 0, '0, 24'h0, 0); #1;
    check_eq("t2_rvalid_early", 32'(pdi_rvalid), 32'd0); tick();
    #1;
    check_eq("t2_rvalid", 32'(pdi_rvalid), 32'd1);
    check_eq("t2_rdata", 32'(pdi_rdata), 32'h123456);
    check_eq("t2_com_rvalid", 32'(com_rvalid), 32'd0);
    tick();

    // fair bursts from reset, then pdi_lock rises while com owns
    rst = 1'b0; tick(); rst = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      drive(1, 1'($urandom), 17'($urandom_range(0, 31)), 2'($urandom), 8'($urandom),
            1, 1'($urandom), 17'($urandom_range(0, 31)), 24'($urandom), k >= 40);
      #1; gc[k] = com_gnt; gp[k] = pdi_gnt;
      tick();
    end
    check_eq("burst_first_idle", 32'(gc[1] | gp[1]), 32'd0);
    s0 = 0; s1 = 0;
    for (int k = 2; k <= 17; k++) begin s0 += int'(gc[k]); s1 += int'(gp[k]); end
    check_eq("burst_com_run", 32'(s0), 32'd16);
    check_eq("burst_com_run_pdi", 32'(s1), 32'd0);
    check_eq("burst_gap1", 32'(gc[18] | gp[18]), 32'd0);
    s0 = 0; s1 = 0;
    for (int k = 19; k <= 34; k++) begin s0 += int'(gc[k]); s1 += int'(gp[k]); end
    check_eq("burst_pdi_run", 32'(s1), 32'd16);
    check_eq("burst_pdi_run_com", 32'(s0), 32'd0);
    check_eq("burst_gap2", 32'(gc[35] | gp[35]), 32'd0);
    check_eq("burst_com_again", 32'(gc[36]), 32'd1);
    check_eq("lock_gap", 32'(gc[41] | gp[41]), 32'd0);
    s0 = 0; s1 = 0;
    for (int k = 42; k <= 61; k++) begin s0 += int'(gc[k]); s1 += int'(gp[k]); end
    check_eq("lock_pdi_run", 32'(s1), 32'd20);
    check_eq("lock_com_starved", 32'(s0), 32'd0);

    // com read of B lane, handed over immediately to a locked pdi write
    drive(0, 0, '0, 2'd0, 8'h00, 0, 0, '0, 24'h0, 0); tick();
    drive(0, 0, '0, 2'd0, 8'h00, 1, 1, 17'd7, 24'hC0FFEE, 0); tick();
    drive(0, 0, '0, 2'd0, 8'h00, 1, 1, 17'd7, 24'hC0FFEE, 0); tick();
    drive(1, 0, 17'd7, 2'd2, 8'h00, 0, 0, '0, 24'h0, 0); tick();
    drive(1, 0, 17'd7, 2'd2, 8'h00, 0, 0, '0, 24'h0, 0); tick();
    drive(1, 0, 17'd7, 2'd2, 8'h00, 1, 1, 17'd9, 24'h5A5A5A, 1); #1;
    check_eq("ho_com_gnt", 32'(com_gnt), 32'd1); tick();
    drive(0, 0, '0, 2'd0, 8'h00, 1, 1, 17'd9, 24'h5A5A5A, 1); tick();
    #1;
    check_eq("ho_com_rvalid", 32'(com_rvalid), 32'd1);
    check_eq("ho_com_rdata", 32'(com_rdata), 32'hEE);
    check_eq("ho_pdi_gnt", 32'(pdi_gnt), 32'd1);
    tick();
    drive(0, 0, '0, 2'd0, 8'h00, 0, 0, '0, 24'h0, 0); #1;
    check_eq("ho_we", 32'(mem_we), 32'b111);
    check_eq("ho_wdata", 32'(mem_wdata), 32'h5A5A5A);
    tick();

    // reset with a com read in flight
    drive(1, 0, 17'd3, 2'd0, 8'h00, 0, 0, '0, 24'h0, 0); tick();
    drive(1, 0, 17'd3, 2'd0, 8'h00, 0, 0, '0, 24'h0, 0); #1;
    check_eq("rs_gnt", 32'(com_gnt), 32'd1); tick();
    drive(0, 0, '0, 2'd0, 8'h00, 0, 0, '0, 24'h0, 0); rst = 1'b0; tick();
    rst = 1'b1; #1;
    check_eq("rs_com_rvalid", 32'(com_rvalid), 32'd0);
    check_eq("rs_pdi_rvalid", 32'(pdi_rvalid), 32'd0);
    check_eq("rs_owner", 32'(owner), 32'd0);
    check_eq("rs_mem_we", 32'(mem_we), 32'd0);
    check_eq("rs_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rs_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rs_com_rdata", 32'(com_rdata), 32'd0);
    tick();
    #1; check_eq("rs_com_rvalid_late", 32'(com_rvalid), 32'd0); tick();

    // random traffic
    lk = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) lk = ~lk;
      drive($urandom_range(0, 9) < 6, 1'($urandom), 17'($urandom_range(0, 31)), 2'($urandom),
            8'($urandom), $urandom_range(0, 9) < 5, 1'($urandom), 17'($urandom_range(0, 31)),
            24'($urandom), lk);
      rst = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
